// File: rtl/plane_sprite_layer_pkg.sv
// plane_sprite_layer_pkg: shared display constants, pipeline stage type and colour select helper
package plane_sprite_layer_pkg;

    localparam int COLOR_W    = 4;
    localparam int RGB_W      = 3 * COLOR_W;
    localparam int H_DISP_LEN = 640;
    localparam int V_DISP_LEN = 480;
    localparam int SPR_SIZE   = 32;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Per-pixel control that travels alongside the ROM access
    typedef struct packed {
        logic hit;
        logic disp;
        logic hs;
        logic vs;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{hit: 1'b0, disp: 1'b0, hs: 1'b1, vs: 1'b1};

    // Blanking forces black; transparent sprite texels fall through to the background
    function automatic rgb_t pick_rgb(input logic disp, input logic hit,
                                      input logic [RGB_W-1:0] rom,
                                      input logic [RGB_W-1:0] key,
                                      input logic [RGB_W-1:0] bg);
        return !disp ? '0 : (hit && rom != key) ? rgb_t'(rom) : rgb_t'(bg);
    endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// sprite_hit_calc: combinational sprite hit test and texel address generator
module sprite_hit_calc #(
    parameter int H_W      = 10,
    parameter int V_W      = 10,
    parameter int SPR_SIZE = 32
) (
    input  logic [H_W-1:0]                   h_i,
    input  logic [V_W-1:0]                   v_i,
    input  logic [H_W-1:0]                   x_i,
    input  logic [V_W-1:0]                   y_i,
    input  logic                             disp_i,
    output logic                             hit_o,
    output logic [2*$clog2(SPR_SIZE)-1:0]    addr_o
);

    localparam int SB = $clog2(SPR_SIZE);
    localparam logic [H_W:0] SPR_H = (H_W+1)'(SPR_SIZE);
    localparam logic [V_W:0] SPR_V = (V_W+1)'(SPR_SIZE);

    logic [H_W:0] dx;
    logic [V_W:0] dy;

    // One extra bit keeps pixels left of / above the sprite negative instead of wrapping
    always_comb begin
        dx     = {1'b0, h_i} - {1'b0, x_i};
        dy     = {1'b0, v_i} - {1'b0, y_i};
        hit_o  = disp_i && !dx[H_W] && !dy[V_W] && dx < SPR_H && dy < SPR_V;
        addr_o = {dy[SB-1:0], dx[SB-1:0]};
    end

endmodule

// File: rtl/plane_sprite_layer.sv
// plane_sprite_layer: overlays the player sprite on a flat background with a 3-stage pixel pipeline
module plane_sprite_layer
    import plane_sprite_layer_pkg::*;
#(
    parameter int               H_W       = 10,
    parameter int               V_W       = 10,
    parameter int               SPR_SIZE  = plane_sprite_layer_pkg::SPR_SIZE,
    parameter logic [RGB_W-1:0] BG_COLOR  = 12'h124,
    parameter logic [RGB_W-1:0] KEY_COLOR = 12'hF0F,
    parameter int               INIT_X    = 304,
    parameter int               INIT_Y    = 400
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [H_W-1:0]                req_h_addr_i,
    input  logic [V_W-1:0]                req_v_addr_i,
    input  logic                          disp_i,
    input  logic                          h_sync_i,
    input  logic                          v_sync_i,
    input  logic                          pos_valid_i,
    input  logic [H_W-1:0]                pos_x_i,
    input  logic [V_W-1:0]                pos_y_i,
    output logic                          pos_ready_o,
    output logic [2*$clog2(SPR_SIZE)-1:0] rom_addr_o,
    input  logic [RGB_W-1:0]              rom_data_i,
    output logic [COLOR_W-1:0]            vga_r_o,
    output logic [COLOR_W-1:0]            vga_g_o,
    output logic [COLOR_W-1:0]            vga_b_o,
    output logic                          h_sync_o,
    output logic                          v_sync_o
);

    localparam int AW = 2 * $clog2(SPR_SIZE);

    logic [H_W-1:0] act_x_q, act_x_d, pnd_x_q, pnd_x_d;
    logic [V_W-1:0] act_y_q, act_y_d, pnd_y_q, pnd_y_d;
    logic           pnd_full_q, pnd_full_d;
    logic           commit_q, commit_d;
    logic [AW-1:0]  rom_addr_q, rom_addr_d;
    stage_t         s1_q, s1_d, s2_q, s2_d;
    rgb_t           rgb_q, rgb_d;
    logic [1:0]     sync_q, sync_d;
    logic           hit_c;
    logic [AW-1:0]  addr_c;
    logic           commit, accept;

    sprite_hit_calc #(
        .H_W      (H_W),
        .V_W      (V_W),
        .SPR_SIZE (SPR_SIZE)
    ) u_hit (
        .h_i    (req_h_addr_i),
        .v_i    (req_v_addr_i),
        .x_i    (act_x_q),
        .y_i    (act_y_q),
        .disp_i (disp_i),
        .hit_o  (hit_c),
        .addr_o (addr_c)
    );

    // Position handshake/commit and the three pixel pipeline stages; s1_q.vs doubles as the v_sync history bit
    always_comb begin
        commit     = commit_q && pnd_full_q;
        accept     = pos_valid_i && !pnd_full_q;
        act_x_d    = commit ? pnd_x_q : act_x_q;
        act_y_d    = commit ? pnd_y_q : act_y_q;
        pnd_x_d    = accept ? pos_x_i : pnd_x_q;
        pnd_y_d    = accept ? pos_y_i : pnd_y_q;
        pnd_full_d = accept || (pnd_full_q && !commit_q);
        commit_d   = s1_q.vs && !v_sync_i;
        rom_addr_d = hit_c ? addr_c : rom_addr_q;
        s1_d       = '{hit: hit_c, disp: disp_i, hs: h_sync_i, vs: v_sync_i};
        s2_d       = s1_q;
        rgb_d      = pick_rgb(s2_q.disp, s2_q.hit, rom_data_i, KEY_COLOR, BG_COLOR);
        sync_d     = {s2_q.hs, s2_q.vs};
    end

    // State registers; reset puts the pipeline in blanking with syncs inactive
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_x_q    <= H_W'(INIT_X);
            act_y_q    <= V_W'(INIT_Y);
            pnd_x_q    <= '0;
            pnd_y_q    <= '0;
            pnd_full_q <= 1'b0;
            commit_q   <= 1'b0;
            rom_addr_q <= '0;
            s1_q       <= STAGE_IDLE;
            s2_q       <= STAGE_IDLE;
            rgb_q      <= '0;
            sync_q     <= 2'b11;
        end else begin
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            pnd_x_q    <= pnd_x_d;
            pnd_y_q    <= pnd_y_d;
            pnd_full_q <= pnd_full_d;
            commit_q   <= commit_d;
            rom_addr_q <= rom_addr_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rgb_q      <= rgb_d;
            sync_q     <= sync_d;
        end
    end

    assign pos_ready_o = !pnd_full_q;
    assign rom_addr_o  = rom_addr_q;
    assign vga_r_o     = rgb_q.r;
    assign vga_g_o     = rgb_q.g;
    assign vga_b_o     = rgb_q.b;
    assign h_sync_o    = sync_q[1];
    assign v_sync_o    = sync_q[0];

endmodule

// File: tb/tb_plane_sprite_layer.sv
// tb_plane_sprite_layer: directed scoreboard bench for the sprite layer with a synchronous ROM model
module tb_plane_sprite_layer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  req_h_addr_i = '0, req_v_addr_i = '0, pos_x_i = '0, pos_y_i = '0;
    logic        disp_i = 1'b0, h_sync_i = 1'b1, v_sync_i = 1'b1, pos_valid_i = 1'b0;
    logic        pos_ready_o, h_sync_o, v_sync_o;
    logic [9:0]  rom_addr_o;
    logic [11:0] rom_data_i = '0;
    logic [3:0]  vga_r_o, vga_g_o, vga_b_o;

    logic [11:0] rom [1024];
    logic [13:0] sb [$];
    int          checks = 0, errors = 0;
    int          m_ax, m_ay, m_px, m_py;
    bit          m_full, m_commit, m_vsprev;
    logic [9:0]  m_addr;

    plane_sprite_layer dut (
        .clk          (clk),
        .rst          (rst),
        .req_h_addr_i (req_h_addr_i),
        .req_v_addr_i (req_v_addr_i),
        .disp_i       (disp_i),
        .h_sync_i     (h_sync_i),
        .v_sync_i     (v_sync_i),
        .pos_valid_i  (pos_valid_i),
        .pos_x_i      (pos_x_i),
        .pos_y_i      (pos_y_i),
        .pos_ready_o  (pos_ready_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .vga_r_o      (vga_r_o),
        .vga_g_o      (vga_g_o),
        .vga_b_o      (vga_b_o),
        .h_sync_o     (h_sync_o),
        .v_sync_o     (v_sync_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_ax = 304; m_ay = 400; m_px = 0; m_py = 0;
        m_full = 0; m_commit = 0; m_vsprev = 1; m_addr = '0;
        sb.delete();
        repeat (3) sb.push_back({12'h000, 1'b1, 1'b1});
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_rgb"}, 32'({vga_r_o, vga_g_o, vga_b_o}), 32'h0);
        chk({tag, "_hs"}, 32'(h_sync_o), 32'd1);
        chk({tag, "_vs"}, 32'(v_sync_o), 32'd1);
        chk({tag, "_ready"}, 32'(pos_ready_o), 32'd1);
        chk({tag, "_rom_addr"}, 32'(rom_addr_o), 32'd0);
    endtask

    // Called at a falling edge: check what the DUT shows now, drive one pixel, predict it, advance the model
    task automatic step(input int h, input int v, input bit d, input bit hs, input bit vs,
                        input bit pv = 0, input int px = 0, input int py = 0);
        logic [13:0] e;
        logic [11:0] c;
        int dx, dy, a;
        bit hit, fall;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("pixel", 32'({vga_r_o, vga_g_o, vga_b_o, h_sync_o, v_sync_o}), 32'(e));
        end
        chk("rom_addr", 32'(rom_addr_o), 32'(m_addr));
        chk("ready", 32'(pos_ready_o), 32'(!m_full));
        req_h_addr_i = 10'(h); req_v_addr_i = 10'(v); disp_i = d;
        h_sync_i = hs; v_sync_i = vs;
        pos_valid_i = pv; pos_x_i = 10'(px); pos_y_i = 10'(py);
        dx = h - m_ax; dy = v - m_ay;
        hit = d && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
        a = hit ? dy * 32 + dx : 0;
        c = !d ? 12'h000 : (hit && rom[a] != 12'hF0F) ? rom[a] : 12'h124;
        sb.push_back({c, hs, vs});
        if (hit) m_addr = 10'(a);
        fall = m_vsprev && !vs;
        if (m_commit && m_full) begin
            m_ax = m_px; m_ay = m_py; m_full = 0;
        end else if (pv && !m_full) begin
            m_px = px; m_py = py; m_full = 1;
        end
        m_commit = fall;
        m_vsprev = vs;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 12'(i * 37 + 5);
        rom[166] = 12'hABC;
        rom[307] = 12'h5A5;
        rom[325] = 12'h3C3;
        repeat (2) @(negedge clk);
        reset_outputs("reset");
        rst = 1'b1;
        reset_model();
        idle(4);
        // sprite texel at (6,5) of sprite placed at (304,400)
        step(310, 405, 1, 1, 1);
        idle(3);
        // transparent texel and a pixel just left of the sprite
        rom[166] = 12'hF0F;
        step(310, 405, 1, 1, 1);
        step(303, 405, 1, 1, 1);
        idle(3);
        // horizontal sweep across both sprite edges with h_sync pulsing
        for (int h = 298; h <= 338; h++) step(h, 405, 1, h >= 305 && h < 310 ? 1'b0 : 1'b1, 1);
        for (int v = 396; v <= 434; v++) step(320, v, 1, 1, 1);
        step(304, 400, 1, 1, 1);
        step(335, 431, 1, 1, 1);
        step(336, 431, 1, 1, 1);
        step(335, 432, 1, 1, 1);
        idle(3);
        // first offer accepted, second while full ignored
        step(0, 0, 0, 1, 1, 1, 620, 470);
        step(0, 0, 0, 1, 1, 1, 100, 100);
        idle(2);
        step(311, 405, 1, 1, 1);
        step(639, 479, 1, 1, 1);
        idle(3);
        // frame boundary: offer on the commit cycle is refused because pending is full
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 100, 100);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        idle(2);
        step(639, 479, 1, 1, 1);
        step(620, 470, 1, 1, 1);
        step(311, 405, 1, 1, 1);
        step(640, 479, 0, 1, 1);
        idle(3);
        // offer on the commit cycle with pending empty lands one frame later
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 200, 150);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        idle(2);
        step(639, 479, 1, 1, 1);
        step(205, 160, 1, 1, 1);
        idle(3);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        idle(2);
        step(205, 160, 1, 1, 1);
        step(639, 479, 1, 1, 1);
        idle(3);
        // reset mid-pipeline with a pending position
        step(0, 0, 0, 1, 1, 1, 50, 50);
        step(210, 155, 1, 0, 1);
        step(211, 156, 1, 1, 0);
        rst = 1'b0;
        #1;
        reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        idle(3);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        idle(2);
        step(60, 60, 1, 1, 1);
        step(311, 405, 1, 1, 1);
        step(210, 155, 1, 1, 1);
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
